// File: rtl/controlador_acoes.sv
// controlador_acoes: samples b1/b2 per tick window and drives the pet state.
// Ports: clk, rst_n, b1, b2, fome, felicidade, sono -> estado, tick, ativ_cnt, alerta.
// Optional death/revival path: define CONTROLADOR_MORTE_EN.
module controlador_acoes #(
  parameter int STAT_W   = 8,
  parameter int TICK_DIV = 1000000,
  parameter int MAX_ATIV = 30,
  parameter int LIMIAR   = 16,
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1,
  localparam int AW = (MAX_ATIV == 0) ? 1 : $clog2(MAX_ATIV + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              b1,
  input  logic              b2,
  input  logic [STAT_W-1:0] fome,
  input  logic [STAT_W-1:0] felicidade,
  input  logic [STAT_W-1:0] sono,
  output logic [3:0]        estado,
  output logic              tick,
  output logic [AW-1:0]     ativ_cnt,
  output logic              alerta
);

  localparam logic [3:0] IDLE       = 4'b0000;
  localparam logic [3:0] DORMINDO   = 4'b0001;
  localparam logic [3:0] COMENDO    = 4'b0010;
  localparam logic [3:0] DANDO_AULA = 4'b0100;
`ifdef CONTROLADOR_MORTE_EN
  localparam logic [3:0] MORTO      = 4'b1000;
`endif

  localparam logic [STAT_W:0] LIM = (STAT_W + 1)'(LIMIAR);

  logic [CW-1:0] div;
  logic          l1;
  logic          l2;
  logic          last;
  logic          p1;
  logic          p2;
  logic          low;
  logic [3:0]    est_d;
  logic [AW-1:0] cnt_d;
  logic          alerta_d;

  assign last = (div == CW'(TICK_DIV - 1));
  assign p1   = l1 | b1;
  assign p2   = l2 | b2;

  assign low = ({1'b0, fome} < LIM) |
               ({1'b0, felicidade} < LIM) |
               ({1'b0, sono} < LIM);

`ifdef CONTROLADOR_MORTE_EN
  logic zero;
  assign zero = (fome == '0) | (felicidade == '0) | (sono == '0);
`endif

  always_comb begin
    est_d = estado;
    cnt_d = ativ_cnt;
    if (last) begin
      cnt_d = '0;
      priority case (1'b1)
`ifdef CONTROLADOR_MORTE_EN
        (zero && estado != MORTO): est_d = MORTO;
        (estado == MORTO): begin
          if (p1 && p2 && !zero) est_d = IDLE;
        end
`endif
        (estado == IDLE): begin
          if (p1 && p2)      est_d = DANDO_AULA;
          else if (p1)       est_d = COMENDO;
          else if (p2)       est_d = DORMINDO;
          else               est_d = IDLE;
        end
        default: begin
          if (p1 || p2) begin
            est_d = IDLE;
          end else if (MAX_ATIV != 0 &&
                       ativ_cnt == AW'(MAX_ATIV - 1)) begin
            est_d = IDLE;
          end else begin
            // saturating only matters when the timeout is disabled
            cnt_d = (&ativ_cnt) ? ativ_cnt : ativ_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CONTROLADOR_MORTE_EN
  assign alerta_d = low & (est_d != MORTO);
`else
  assign alerta_d = low;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      l1       <= 1'b0;
      l2       <= 1'b0;
      estado   <= IDLE;
      tick     <= 1'b0;
      ativ_cnt <= '0;
      alerta   <= 1'b0;
    end else begin
      div      <= last ? '0 : div + 1'b1;
      // latches are consumed by the decision edge they feed
      l1       <= last ? 1'b0 : p1;
      l2       <= last ? 1'b0 : p2;
      estado   <= est_d;
      tick     <= last;
      ativ_cnt <= cnt_d;
      alerta   <= alerta_d;
    end
  end

endmodule

// File: tb/tb_controlador_acoes.sv
// tb_controlador_acoes: scoreboard bench for controlador_acoes.
// Expected (estado, ativ_cnt) pushed per window, popped at each tick.
module tb_controlador_acoes;

  localparam logic [3:0] IDLE = 4'b0000;
  localparam logic [3:0] DORM = 4'b0001;
  localparam logic [3:0] COM  = 4'b0010;
  localparam logic [3:0] AULA = 4'b0100;
  localparam logic [3:0] MORT = 4'b1000;

  typedef struct packed {
    logic [3:0] e;
    logic [1:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b1 = 1'b0;
  logic       b2 = 1'b0;
  logic [7:0] fome = 8'd100;
  logic [7:0] felicidade = 8'd100;
  logic [7:0] sono = 8'd100;
  logic [3:0] estado;
  logic       tick;
  logic [1:0] ativ_cnt;
  logic       alerta;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  controlador_acoes #(
    .STAT_W(8),
    .TICK_DIV(4),
    .MAX_ATIV(3),
    .LIMIAR(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .b1(b1),
    .b2(b2),
    .fome(fome),
    .felicidade(felicidade),
    .sono(sono),
    .estado(estado),
    .tick(tick),
    .ativ_cnt(ativ_cnt),
    .alerta(alerta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one full window, entered and left at a falling edge
  task automatic janela(input logic [3:0] m1,
                        input logic [3:0] m2,
                        input logic [3:0] e,
                        input logic [1:0] c);
    exp_t x;
    sb.push_back('{e: e, c: c});
    for (int i = 0; i < 4; i++) begin
      b1 = m1[i];
      b2 = m2[i];
      @(posedge clk);
      #1;
      if (i < 3) chk("tick_lo", tick, 0);
    end
    b1 = 1'b0;
    b2 = 1'b0;
    chk("tick_hi", tick, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("estado", estado, x.e);
      chk("ativ_cnt", ativ_cnt, x.c);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_estado", estado, IDLE);
    chk("rst_tick", tick, 0);
    chk("rst_cnt", ativ_cnt, 0);
    chk("rst_alerta", alerta, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle ticks at edges 4, 8, 12
    janela(4'b0000, 4'b0000, IDLE, 2'd0);
    janela(4'b0000, 4'b0000, IDLE, 2'd0);
    janela(4'b0000, 4'b0000, IDLE, 2'd0);

    // single-cycle pulses
    janela(4'b0010, 4'b0000, COM, 2'd0);
    janela(4'b0000, 4'b0100, IDLE, 2'd0);

    // both buttons in one window, then timeout
    janela(4'b0001, 4'b0100, AULA, 2'd0);
    janela(4'b0000, 4'b0000, AULA, 2'd1);
    janela(4'b0000, 4'b0000, AULA, 2'd2);
    janela(4'b0000, 4'b0000, IDLE, 2'd0);

    // held button counts in consecutive windows
    janela(4'b1000, 4'b0000, COM, 2'd0);
    janela(4'b1111, 4'b0000, IDLE, 2'd0);
    janela(4'b1111, 4'b0000, COM, 2'd0);
    janela(4'b0000, 4'b0000, COM, 2'd1);

    // reset mid-activity with b1 latched
    b1 = 1'b1;
    @(posedge clk);
    #1;
    b1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_estado", estado, IDLE);
    chk("arst_tick", tick, 0);
    chk("arst_cnt", ativ_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    janela(4'b0000, 4'b0000, IDLE, 2'd0);

`ifdef CONTROLADOR_MORTE_EN
    janela(4'b0000, 4'b0001, DORM, 2'd0);
    sono = 8'd0;
    janela(4'b0000, 4'b0010, MORT, 2'd0);
    chk("dead_alerta", alerta, 0);
    janela(4'b0001, 4'b0100, MORT, 2'd0);
    sono = 8'd50;
    janela(4'b0010, 4'b0010, IDLE, 2'd0);
    chk("rev_alerta", alerta, 0);
`else
    fome = 8'd0;
    #1;
    chk("alerta_lag", alerta, 0);
    janela(4'b0001, 4'b0000, COM, 2'd0);
    chk("alerta_on", alerta, 1);
    chk("never_morto", estado == MORT, 0);
    fome = 8'd20;
    #1;
    chk("alerta_hold", alerta, 1);
    janela(4'b0000, 4'b0000, COM, 2'd1);
    chk("alerta_off", alerta, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
